// File: rtl/vga_ctrl_pkg.sv
// Shared definitions for the analog video output mode controller:
// FSM state encodings and counter width sizing.
package vga_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN     = 2'd0;
    localparam state_t ST_WAIT_VS = 2'd1;
    localparam state_t ST_MUTE    = 2'd2;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 32'sd1;
        while ((32'sd1 <<< w) <= max_val) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/vga_sync_mon.sv
// Registers hsync/vsync, detects their rising edges and runs a saturating
// hsync-activity watchdog that flags loss of signal.
module vga_sync_mon
    import vga_ctrl_pkg::*;
#(
    parameter int HS_TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic hsync,
    input  logic vsync,
    output logic vs_rise,
    output logic no_signal
);

    localparam int HC_W = cnt_width(HS_TIMEOUT);
    localparam logic [HC_W-1:0] HC_MAX  = HC_W'(HS_TIMEOUT);
    localparam logic [HC_W-1:0] HC_ONE  = HC_W'(32'd1);
    localparam logic [HC_W-1:0] HC_ZERO = HC_W'(32'd0);

    logic            hs_r;
    logic            hs_d_r;
    logic            vs_r;
    logic            vs_d_r;
    logic            hs_rise_s;
    logic [HC_W-1:0] hs_cnt_r;
    logic [HC_W-1:0] hs_cnt_nxt_s;
    logic            no_signal_r;

    assign hs_rise_s = hs_r & ~hs_d_r;
    assign vs_rise   = vs_r & ~vs_d_r;
    assign no_signal = no_signal_r;

    // Input capture plus one extra stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_r   <= 1'b0;
            hs_d_r <= 1'b0;
            vs_r   <= 1'b0;
            vs_d_r <= 1'b0;
        end else begin
            hs_r   <= hsync;
            hs_d_r <= hs_r;
            vs_r   <= vsync;
            vs_d_r <= vs_r;
        end
    end

    // Clocks since the last hsync edge, pinned at the timeout value.
    always_comb begin
        hs_cnt_nxt_s = hs_cnt_r;
        if (hs_rise_s) begin
            hs_cnt_nxt_s = HC_ZERO;
        end else if (hs_cnt_r != HC_MAX) begin
            hs_cnt_nxt_s = hs_cnt_r + HC_ONE;
        end else begin
            hs_cnt_nxt_s = hs_cnt_r;
        end
    end

    // Watchdog counter and its registered timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_cnt_r    <= HC_ZERO;
            no_signal_r <= 1'b0;
        end else begin
            hs_cnt_r    <= hs_cnt_nxt_s;
            no_signal_r <= (hs_cnt_nxt_s == HC_MAX);
        end
    end

endmodule

// File: rtl/vga_mode_ctrl.sv
// Output-stage mode sequencer: defers RGB/YPbPr switches to a vsync edge,
// mutes a programmable number of frames afterwards, and blanks on sync loss.
module vga_mode_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter int MUTE_FRAMES = 2,
    parameter int HS_TIMEOUT  = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic ypbpr_req,
    input  logic hsync,
    input  logic vsync,
    output logic ypbpr_en,
    output logic blank,
    output logic busy,
    output logic no_signal
);

    localparam int FC_W = cnt_width(MUTE_FRAMES);
    localparam logic [FC_W-1:0] FC_INIT = FC_W'(MUTE_FRAMES);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(32'd1);
    localparam logic [FC_W-1:0] FC_ZERO = FC_W'(32'd0);
    localparam logic            NO_MUTE = (MUTE_FRAMES == 0);

    logic            req_r;
    logic            en_r;
    logic            en_nxt_s;
    state_t          state_r;
    state_t          state_nxt_s;
    logic [FC_W-1:0] fc_r;
    logic [FC_W-1:0] fc_nxt_s;
    logic            vs_rise_s;
    logic            no_signal_s;

    vga_sync_mon #(
        .HS_TIMEOUT (HS_TIMEOUT)
    ) u_sync_mon (
        .clk       (clk),
        .reset     (reset),
        .hsync     (hsync),
        .vsync     (vsync),
        .vs_rise   (vs_rise_s),
        .no_signal (no_signal_s)
    );

    // Mode sequencing; sync loss overrides the wait for vsync and the mute.
    always_comb begin
        state_nxt_s = state_r;
        fc_nxt_s    = fc_r;
        en_nxt_s    = en_r;
        case (state_r)
            ST_RUN: begin
                if (req_r != en_r) begin
                    state_nxt_s = ST_WAIT_VS;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_WAIT_VS: begin
                if (req_r == en_r) begin
                    state_nxt_s = ST_RUN;
                end else if (no_signal_s) begin
                    en_nxt_s    = req_r;
                    state_nxt_s = ST_RUN;
                end else if (vs_rise_s) begin
                    en_nxt_s    = req_r;
                    fc_nxt_s    = FC_INIT;
                    state_nxt_s = NO_MUTE ? ST_RUN : ST_MUTE;
                end else begin
                    state_nxt_s = ST_WAIT_VS;
                end
            end
            ST_MUTE: begin
                if (no_signal_s) begin
                    state_nxt_s = ST_RUN;
                end else if (req_r != en_r) begin
                    state_nxt_s = ST_WAIT_VS;
                end else if (fc_r == FC_ZERO) begin
                    state_nxt_s = ST_RUN;
                end else if (vs_rise_s) begin
                    fc_nxt_s    = fc_r - FC_ONE;
                    state_nxt_s = (fc_r == FC_ONE) ? ST_RUN : ST_MUTE;
                end else begin
                    state_nxt_s = ST_MUTE;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a fresh mute sequence.
                state_nxt_s = ST_MUTE;
                fc_nxt_s    = FC_INIT;
            end
        endcase
    end

    // Request capture and FSM state; reset drops any pending change.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_r   <= 1'b0;
            state_r <= ST_MUTE;
            fc_r    <= FC_INIT;
            en_r    <= 1'b0;
        end else begin
            req_r   <= ypbpr_req;
            state_r <= state_nxt_s;
            fc_r    <= fc_nxt_s;
            en_r    <= en_nxt_s;
        end
    end

    assign ypbpr_en  = en_r;
    assign busy      = (state_r != ST_RUN);
    assign blank     = (state_r != ST_RUN) | no_signal_s;
    assign no_signal = no_signal_s;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Randomized bench: three parameterisations of vga_mode_ctrl share one
// stimulus stream and are compared every cycle against a flag-based model.
module tb_vga_mode_ctrl;

    localparam int NCYC = 60000;
    localparam int NI   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       ypbpr_req;
    logic       hsync;
    logic       vsync;
    logic [2:0] en_o;
    logic [2:0] blank_o;
    logic [2:0] busy_o;
    logic [2:0] ns_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    vga_mode_ctrl #(.MUTE_FRAMES(2), .HS_TIMEOUT(4096)) u_dut0 (
        .clk(clk), .reset(reset), .ypbpr_req(ypbpr_req), .hsync(hsync), .vsync(vsync),
        .ypbpr_en(en_o[0]), .blank(blank_o[0]), .busy(busy_o[0]), .no_signal(ns_o[0]));

    vga_mode_ctrl #(.MUTE_FRAMES(3), .HS_TIMEOUT(100)) u_dut1 (
        .clk(clk), .reset(reset), .ypbpr_req(ypbpr_req), .hsync(hsync), .vsync(vsync),
        .ypbpr_en(en_o[1]), .blank(blank_o[1]), .busy(busy_o[1]), .no_signal(ns_o[1]));

    vga_mode_ctrl #(.MUTE_FRAMES(0), .HS_TIMEOUT(50)) u_dut2 (
        .clk(clk), .reset(reset), .ypbpr_req(ypbpr_req), .hsync(hsync), .vsync(vsync),
        .ypbpr_en(en_o[2]), .blank(blank_o[2]), .busy(busy_o[2]), .no_signal(ns_o[2]));

    // Reference model: per-instance mode flags plus the shared input pipeline.
    int  mf [NI];
    int  to [NI];
    bit  p_req, p_hs, p_hs_d, p_vs, p_vs_d;
    bit  m_en   [NI];
    bit  m_pend [NI];
    bit  m_mute [NI];
    bit  m_ns   [NI];
    int  m_left [NI];
    int  m_since[NI];

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0b, expected %0b", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit hs_rise;
        bit vs_rise;
        if (reset) begin
            {p_req, p_hs, p_hs_d, p_vs, p_vs_d} = 5'b00000;
            for (int i = 0; i < NI; i++) begin
                m_en[i]    = 1'b0;
                m_pend[i]  = 1'b0;
                m_mute[i]  = 1'b1;
                m_left[i]  = mf[i];
                m_since[i] = 0;
                m_ns[i]    = 1'b0;
            end
        end else begin
            hs_rise = p_hs & ~p_hs_d;
            vs_rise = p_vs & ~p_vs_d;
            for (int i = 0; i < NI; i++) begin
                if (!m_pend[i] && !m_mute[i]) begin
                    if (p_req != m_en[i]) m_pend[i] = 1'b1;
                end else if (m_pend[i]) begin
                    if (p_req == m_en[i]) begin
                        m_pend[i] = 1'b0;
                    end else if (m_ns[i]) begin
                        m_en[i] = p_req;
                        m_pend[i] = 1'b0;
                    end else if (vs_rise) begin
                        m_en[i] = p_req;
                        m_pend[i] = 1'b0;
                        if (mf[i] > 0) begin
                            m_mute[i] = 1'b1;
                            m_left[i] = mf[i];
                        end
                    end
                end else begin
                    if (m_ns[i]) begin
                        m_mute[i] = 1'b0;
                    end else if (p_req != m_en[i]) begin
                        m_mute[i] = 1'b0;
                        m_pend[i] = 1'b1;
                    end else if (m_left[i] == 0) begin
                        m_mute[i] = 1'b0;
                    end else if (vs_rise) begin
                        m_left[i]--;
                        if (m_left[i] == 0) m_mute[i] = 1'b0;
                    end
                end
                if (hs_rise) m_since[i] = 0;
                else if (m_since[i] < to[i]) m_since[i]++;
                m_ns[i] = (m_since[i] >= to[i]);
            end
            p_hs_d = p_hs;
            p_vs_d = p_vs;
            p_hs   = hsync;
            p_vs   = vsync;
            p_req  = ypbpr_req;
        end
    endtask

    string tg_en [NI];
    string tg_bl [NI];
    string tg_bs [NI];
    string tg_ns [NI];

    int hp, vl, hpos, line, hs_stop, pulse_cnt, rst_cnt, r;

    initial begin
        mf[0] = 2; to[0] = 4096;
        mf[1] = 3; to[1] = 100;
        mf[2] = 0; to[2] = 50;
        for (int i = 0; i < NI; i++) begin
            tg_en[i] = $sformatf("u%0d.ypbpr_en", i);
            tg_bl[i] = $sformatf("u%0d.blank", i);
            tg_bs[i] = $sformatf("u%0d.busy", i);
            tg_ns[i] = $sformatf("u%0d.no_signal", i);
        end
        reset = 1'b1; ypbpr_req = 1'b0; hsync = 1'b0; vsync = 1'b0;
        hp = 30; vl = 5; hpos = 0; line = 1;
        hs_stop = 0; pulse_cnt = 0; rst_cnt = 3;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            // Raster timing with randomized line length and frame height.
            hpos++;
            if (hpos >= hp) begin
                hpos = 0;
                line++;
                if (line >= vl) begin
                    line = 0;
                    hp = $urandom_range(20, 40);
                    vl = $urandom_range(3, 6);
                end
            end
            if (hs_stop > 0) hs_stop--;
            else if (cyc == 20000) hs_stop = 4300;
            else if ($urandom_range(0, 2999) == 0)
                hs_stop = ($urandom_range(0, 2) == 0) ? 4150 + $urandom_range(0, 300)
                                                      : $urandom_range(30, 300);
            hsync = (hpos < 4) && (hs_stop == 0);
            vsync = (line == 0);

            // Mode requests: plain toggles and short glitch pulses.
            if (pulse_cnt > 0) begin
                pulse_cnt--;
                if (pulse_cnt == 0) ypbpr_req = ~ypbpr_req;
            end else begin
                r = $urandom_range(0, 999);
                if (r < 3) begin
                    ypbpr_req = ~ypbpr_req;
                end else if (r < 5) begin
                    ypbpr_req = ~ypbpr_req;
                    pulse_cnt = $urandom_range(5, 60);
                end
            end

            if (rst_cnt > 0) rst_cnt--;
            else if ($urandom_range(0, 7999) == 0) rst_cnt = $urandom_range(1, 3);
            reset = (rst_cnt > 0);

            @(posedge clk);
            model_edge();
            #1;
            for (int i = 0; i < NI; i++) begin
                check_bit(tg_en[i], en_o[i],    m_en[i]);
                check_bit(tg_bl[i], blank_o[i], m_pend[i] | m_mute[i] | m_ns[i]);
                check_bit(tg_bs[i], busy_o[i],  m_pend[i] | m_mute[i]);
                check_bit(tg_ns[i], ns_o[i],    m_ns[i]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
